dram_arbiter: RTL and testbench

Two-master arbiter that shares the single port of the data RAM between the CPU load/store path (master 0) and a bulk-transfer engine such as a framebuffer fill/copy unit (master 1). It sits directly in front of the data RAM's `we`/`a`/`wd`/`rd` port. It grants at most one access per cycle, round-robin on contention, with a bounded burst lock for master 1. Read data returns through a registered path with a fixed one-cycle latency.

---
 rtl/dram_arbiter_pkg.sv | 11 +
 rtl/dram_arbiter_if.sv | 42 ++++
 rtl/dram_arbiter_arb_rr2.sv | 28 ++
 rtl/dram_arbiter.sv | 106 ++++++++++
 tb/tb_dram_arbiter.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/dram_arbiter_pkg.sv
// Shared types and constants for the data-RAM arbiter.
package dram_arbiter_pkg;

    typedef enum logic {
        ARB_M0 = 1'b0,
        ARB_M1 = 1'b1
    } arb_sel_e;

    localparam int unsigned DRAM_MAX_BURST = 16;

endpackage

// File: rtl/dram_arbiter_if.sv
// Request/grant/read-return bundle for both masters plus the RAM port.
interface dram_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);

    logic          m0_req;
    logic          m1_req;
    logic          m0_we;
    logic          m1_we;
    logic [AW-1:0] m0_addr;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m0_wdata;
    logic [DW-1:0] m1_wdata;
    logic          m1_lock;
    logic          m0_gnt;
    logic          m1_gnt;
    logic          m0_rvalid;
    logic          m1_rvalid;
    logic [DW-1:0] m0_rdata;
    logic [DW-1:0] m1_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_wd;
    logic [DW-1:0] ram_rd;

    // Requesters and the RAM as seen from outside the arbiter.
    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
        output m0_wdata, m1_wdata, m1_lock, ram_rd,
        input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
        input  ram_we, ram_a, ram_wd
    );

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
        input  m0_wdata, m1_wdata, m1_lock, ram_rd,
        output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
        output ram_we, ram_a, ram_wd
    );

endinterface

// File: rtl/dram_arbiter_arb_rr2.sv
// Combinational 2-way round-robin grant with override inputs; output is one-hot or zero.
module arb_rr2
    import dram_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  arb_sel_e   last,
    input  logic       force_m1,
    input  logic       force_m0,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (force_m1 && req[1]) begin
            gnt = 2'b10;
        end else if (force_m0 && req[0]) begin
            gnt = 2'b01;
        end else begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last == ARB_M1) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Shares the data-RAM port between CPU (m0) and bulk engine (m1): round-robin with m1 burst lock,
// zero-latency grant and a registered one-cycle read return.
module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_BURST = DRAM_MAX_BURST
) (
    input logic           clk,
    input logic           rst,
    dram_arbiter_if.slave bus
);

    localparam int unsigned CntW = $clog2(MAX_BURST + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);

    arb_sel_e      last_gnt_q, last_gnt_d;
    logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
    logic          lock_hold;
    logic          force_m0;
    logic [1:0]    arb_gnt;
    logic [1:0]    gnt;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wdata_mux;
    logic          we_mux;
    logic          m0_rvalid_q, m1_rvalid_q;
    logic [DW-1:0] m0_rdata_q, m1_rdata_q;

    // A non-zero count means m1 won the previous edge with lock set.
    assign lock_hold = (burst_cnt_q != '0) && (burst_cnt_q < MaxCnt) && bus.m1_req;
    assign force_m0  = (burst_cnt_q == MaxCnt) && bus.m0_req;

    arb_rr2 u_arb (
        .req      ({bus.m1_req, bus.m0_req}),
        .last     (last_gnt_q),
        .force_m1 (lock_hold),
        .force_m0 (force_m0),
        .gnt      (arb_gnt)
    );

    assign gnt        = rst ? 2'b00 : arb_gnt;
    assign bus.m0_gnt = gnt[0];
    assign bus.m1_gnt = gnt[1];

    always_comb begin
        addr_mux  = bus.m0_addr;
        wdata_mux = bus.m0_wdata;
        we_mux    = 1'b0;
        unique case (gnt)
            2'b01: we_mux = bus.m0_we;
            2'b10: begin
                addr_mux  = bus.m1_addr;
                wdata_mux = bus.m1_wdata;
                we_mux    = bus.m1_we;
            end
            default: ;
        endcase
    end

    assign bus.ram_a  = addr_mux;
    assign bus.ram_wd = wdata_mux;
    assign bus.ram_we = we_mux;

    always_comb begin
        last_gnt_d  = last_gnt_q;
        burst_cnt_d = '0;
        if (gnt[0]) begin
            last_gnt_d = ARB_M0;
        end
        if (gnt[1]) begin
            last_gnt_d = ARB_M1;
            if (bus.m1_lock) begin
                burst_cnt_d = (burst_cnt_q == MaxCnt) ? MaxCnt : burst_cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q  <= ARB_M1;
            burst_cnt_q <= '0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            last_gnt_q  <= last_gnt_d;
            burst_cnt_q <= burst_cnt_d;
            m0_rvalid_q <= gnt[0] & ~bus.m0_we;
            m1_rvalid_q <= gnt[1] & ~bus.m1_we;
            if (gnt[0] && !bus.m0_we) begin
                m0_rdata_q <= bus.ram_rd;
            end
            if (gnt[1] && !bus.m1_we) begin
                m1_rdata_q <= bus.ram_rd;
            end
        end
    end

    assign bus.m0_rvalid = m0_rvalid_q;
    assign bus.m1_rvalid = m1_rvalid_q;
    assign bus.m0_rdata  = m0_rdata_q;
    assign bus.m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a behavioural RAM and a read-return scoreboard.
module tb_dram_arbiter;

    typedef struct packed {
        logic        m;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];
    logic [31:0] held[2];
    logic [31:0] mem[256];

    dram_arbiter_if #(.AW(32), .DW(32)) bus ();

    dram_arbiter #(
        .AW        (32),
        .DW        (32),
        .MAX_BURST (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: combinational read, write commits on the rising edge.
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_a[7:0]] <= bus.ram_wd;
    end
    assign bus.ram_rd = mem[bus.ram_a[7:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int m, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (m == 0) begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
        end else begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
        end
    endtask

    // One clock: check grant/port mux before the edge, read return after it.
    task automatic cycle(input logic eg0, input logic eg1, input logic [31:0] erd,
                         input string tag);
        logic        ewe;
        logic [31:0] ea, ewd;
        logic        ev0, ev1;
        exp_t        e;
        @(negedge clk);
        ewe = (eg0 & bus.m0_we) | (eg1 & bus.m1_we);
        ea  = eg1 ? bus.m1_addr : bus.m0_addr;
        ewd = eg1 ? bus.m1_wdata : bus.m0_wdata;
        chk({tag, "/m0_gnt"}, 32'(bus.m0_gnt), 32'(eg0));
        chk({tag, "/m1_gnt"}, 32'(bus.m1_gnt), 32'(eg1));
        chk({tag, "/ram_we"}, 32'(bus.ram_we), 32'(ewe));
        chk({tag, "/ram_a"}, bus.ram_a, ea);
        chk({tag, "/ram_wd"}, bus.ram_wd, ewd);
        if (eg0 && !bus.m0_we) sb.push_back('{m: 1'b0, d: erd});
        if (eg1 && !bus.m1_we) sb.push_back('{m: 1'b1, d: erd});
        @(posedge clk);
        #1;
        ev0 = 1'b0;
        ev1 = 1'b0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            held[e.m] = e.d;
            ev0 = ~e.m;
            ev1 = e.m;
        end
        chk({tag, "/m0_rvalid"}, 32'(bus.m0_rvalid), 32'(ev0));
        chk({tag, "/m1_rvalid"}, 32'(bus.m1_rvalid), 32'(ev1));
        chk({tag, "/m0_rdata"}, bus.m0_rdata, held[0]);
        chk({tag, "/m1_rdata"}, bus.m1_rdata, held[1]);
    endtask

    initial begin
        held[0] = '0;
        held[1] = '0;
        rst = 1'b1;
        bus.m1_lock = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle(1'b0, 1'b0, 32'd0, "rst0");
        cycle(1'b0, 1'b0, 32'd0, "rst1");
        rst = 1'b0;
        cycle(1'b0, 1'b0, 32'd0, "idle");

        // Write then immediate read-back by m0.
        drive(0, 1'b1, 1'b1, 32'd0, 32'h1);
        cycle(1'b1, 1'b0, 32'd0, "wr0");
        drive(0, 1'b1, 1'b0, 32'd0, 32'd0);
        cycle(1'b1, 1'b0, 32'h1, "rd0");
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle(1'b0, 1'b0, 32'd0, "rd0_done");

        // Preload, leaving last_gnt = M1.
        drive(0, 1'b1, 1'b1, 32'd100, 32'd66);
        cycle(1'b1, 1'b0, 32'd0, "pre100");
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b1, 1'b1, 32'd1, 32'd77);
        cycle(1'b0, 1'b1, 32'd0, "pre1");

        // Continuous contention without lock alternates, m0 first.
        drive(0, 1'b1, 1'b0, 32'd100, 32'd0);
        drive(1, 1'b1, 1'b0, 32'd1, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle((i % 2) == 0, (i % 2) == 1, ((i % 2) == 0) ? 32'd66 : 32'd77, "rr");
        end
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle(1'b0, 1'b0, 32'd0, "rr_done");

        // Locked burst: four m1 grants, then m0, then m1 resumes.
        bus.m1_lock = 1'b1;
        drive(1, 1'b1, 1'b0, 32'd1, 32'd0);
        cycle(1'b0, 1'b1, 32'd77, "bst0");
        drive(0, 1'b1, 1'b0, 32'd100, 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'd77, "bst_lock");
        cycle(1'b1, 1'b0, 32'd66, "bst_m0");
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle(1'b0, 1'b1, 32'd77, "bst_resume");
        bus.m1_lock = 1'b0;
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle(1'b0, 1'b0, 32'd0, "bst_done");

        // Reset right after a granted read drops rvalid, clears rdata, blocks writes.
        drive(0, 1'b1, 1'b0, 32'd0, 32'd0);
        cycle(1'b1, 1'b0, 32'h1, "rd_pre_rst");
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b1, 1'b1, 32'd5, 32'hEE);
        rst = 1'b1;
        held[0] = '0;
        held[1] = '0;
        cycle(1'b0, 1'b0, 32'd0, "rst_mid");
        rst = 1'b0;
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle(1'b0, 1'b0, 32'd0, "post_rst");

        // Write contention on one address: m0 commits first, m1 last.
        drive(0, 1'b1, 1'b1, 32'd5, 32'hAA);
        drive(1, 1'b1, 1'b1, 32'd5, 32'hBB);
        cycle(1'b1, 1'b0, 32'd0, "wc_m0");
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle(1'b0, 1'b1, 32'd0, "wc_m1");
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(0, 1'b1, 1'b0, 32'd5, 32'd0);
        cycle(1'b1, 1'b0, 32'hBB, "wc_rd");
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle(1'b0, 1'b0, 32'd0, "end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
